clk_gate_bank: RTL
==================

Name: clk_gate_bank

Overview:
- Multi-channel, parametrised successor to the single latch-based integrated clock-gate cells.
- Each of NCH channels gates CLK with its own enable. Each channel has a programmable hold-off (hysteresis) counter, so short enable dips do not toggle the gate.
- Latch-based, glitch-free positive-edge gating; scan enable overrides all channels.
- Sits between the clock root and per-domain leaf logic; gating status is reported to power management.

Parameters:
- NCH, 4, number of gated channels (1..32).
- HOLD_W, 4, width of the hold-off counter and of each HOLD_CYC field.
- RST_ON, 1, channel state after reset: 1 = RUN (clock running), 0 = OFF (gated).

Ports:
- CLK  input  1  free-running source clock.
- RSTN  input  1  asynchronous, active-low reset.
- E  input  NCH  per-channel functional enable, sampled on CLK posedge.
- SE  input  1  scan/test enable; forces every channel on.
- HOLD_CYC  input  NCH*HOLD_W  per-channel hold-off length in cycles; channel i occupies bits [i*HOLD_W +: HOLD_W]; quasi-static.
- GCLK  output  NCH  gated clocks.
- GATED  output  NCH  registered flag: channel i is in state OFF.
- IDLE_ALL  output  1  registered AND of all GATED bits.
- STAT_SEL  input  5  channel select for statistics readout (used bits = clog2(NCH)).
- STAT_CLR  input  1  synchronous clear of all statistics counters.
- STAT_DATA  output  16  gated-cycle count of the selected channel.

Behaviour:
- Reset (RSTN=0, asynchronous): all channels enter RUN if RST_ON=1, otherwise OFF.
  - Hold counters reset to 0.
  - Enable latches are forced to RST_ON.
  - GATED and IDLE_ALL reset to ~RST_ON.
  - STAT counters reset to 0.
- Per-channel request: req[i] = E[i] | SE.
- Per-channel state machine, updated on CLK posedge:
  - RUN: if req=0 and HOLD_CYC[i]=0, go to OFF. If req=0 and HOLD_CYC[i]>0, go to HOLD with cnt=HOLD_CYC[i]-1. Otherwise stay in RUN.
  - HOLD: if req=1, go to RUN. Else if cnt=0, go to OFF. Else cnt decrements by 1.
  - OFF: if req=1, go to RUN.
- en_ff[i] = (state != OFF).
- Enable latch: transparent while CLK=0, opaque while CLK=1. It captures en_ff[i] | SE.
  - GCLK[i] = CLK & en_lat[i]. No glitches are allowed.
  - SE is also ORed at the latch input, so SE takes effect at the next CLK low phase without waiting for a posedge.
- Latency:
  - Wake: E rises before posedge k; first GCLK high pulse is at posedge k+1.
  - Gate: E falls before posedge k; the last GCLK pulse is at posedge k+HOLD_CYC. GCLK then stays low from posedge k+HOLD_CYC+1 onward.
- Boundary cases:
  - E toggling within the hold window (req returns while in HOLD) never gates the clock.
  - HOLD_CYC changes are picked up only on the next RUN to HOLD transition.
  - E high during reset: the first posedge after RSTN rises moves the channel to RUN regardless of RST_ON.
  - Reset asserted mid-HOLD: the hold count is discarded.
- GATED[i] is a registered copy of (state==OFF), updated on the same edge as the state. IDLE_ALL = &GATED.
- Channels are independent; simultaneous events on different channels do not interact.

Optional Feature:
- CLK_GATE_STATS_EN defined:
  - Each channel has a 16-bit saturating counter that increments on every CLK posedge where the channel state is OFF, and holds at 16'hFFFF.
  - STAT_CLR=1 zeroes all counters at the next posedge and takes priority over increment.
  - STAT_DATA = counter[STAT_SEL] (combinational mux). STAT_SEL>=NCH returns 0.
- CLK_GATE_STATS_EN undefined: no counters are built; STAT_DATA is tied to 16'h0; STAT_SEL and STAT_CLR are ignored.

Test Plan:
- Reset with RST_ON=1, NCH=4, E=0, HOLD_CYC=0 -> GCLK toggles during the first cycle after RSTN rises; all channels are OFF after posedge 1; GCLK is low from posedge 2; GATED=4'hF and IDLE_ALL=1.
- Ch0 HOLD_CYC=3, E[0] falls before posedge 10 -> GCLK[0] pulses at posedges 11, 12 and 13, and is low from posedge 14; GATED[0]=1 after posedge 13.
- Ch1 HOLD_CYC=5, E[1] low for 2 cycles then high -> GCLK[1] shows no missing pulse; GATED[1] stays 0.
- All channels OFF, SE=1 applied mid-cycle -> every GCLK runs from the next CLK high phase; SE=0 with E=0 and HOLD_CYC=0 -> clocks gate again after 1 cycle. Checker asserts no GCLK pulse narrower than CLK high time.
- Reset asserted while ch2 is in HOLD with cnt=2 -> ch2 enters the RST_ON state immediately; GCLK[2] follows with no runt pulse.
- With CLK_GATE_STATS_EN: ch3 OFF for 20 cycles, STAT_SEL=3 -> STAT_DATA=20; STAT_CLR pulse -> STAT_DATA=0; ch3 OFF for 70000 cycles -> STAT_DATA=16'hFFFF.

Source files
------------

// File: rtl/clk_gate_bank.sv
// clk_gate_bank: NCH latch-based positive-edge clock gates, each with a hold-off counter.
// Define CLK_GATE_STATS_EN to build per-channel 16-bit gated-cycle counters behind STAT_DATA.
`timescale 1ns/1ps

module clk_gate_chan #(
    parameter int HOLD_W = 4,
    parameter bit RST_ON = 1'b1
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              i_req,
    input  logic              i_se,
    input  logic [HOLD_W-1:0] i_hold,
    output logic              o_gclk,
    output logic              o_off_nxt,
    output logic              o_off
);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_HOLD = 2'd1, S_OFF = 2'd2} state_t;
    localparam state_t S_RST = RST_ON ? S_RUN : S_OFF;

    state_t            r_state, w_state_nxt;
    logic [HOLD_W-1:0] r_cnt, w_cnt_nxt;
    logic              r_en_lat;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= S_RST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // HOLD_CYC is only sampled on entry to HOLD; after that the private count runs down.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (!i_req) begin
                    if (i_hold == '0) begin
                        w_state_nxt = S_OFF;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = i_hold - 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (i_req)              w_state_nxt = S_RUN;
                else if (r_cnt == '0)   w_state_nxt = S_OFF;
                else                    w_cnt_nxt   = r_cnt - 1'b1;
            end
            S_OFF: begin
                if (i_req) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RST;
        endcase
    end

    // SE at the latch input lets scan take over within the current low phase.
    always_latch begin
        if (!RSTN)     r_en_lat <= RST_ON;
        else if (!CLK) r_en_lat <= (r_state != S_OFF) | i_se;
    end

    assign o_gclk    = CLK & r_en_lat;
    assign o_off_nxt = (w_state_nxt == S_OFF);
    assign o_off     = (r_state == S_OFF);
endmodule

module clk_gate_bank #(
    parameter int NCH    = 4,
    parameter int HOLD_W = 4,
    parameter bit RST_ON = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [NCH-1:0]        E,
    input  logic                  SE,
    input  logic [NCH*HOLD_W-1:0] HOLD_CYC,
    output logic [NCH-1:0]        GCLK,
    output logic [NCH-1:0]        GATED,
    output logic                  IDLE_ALL,
    input  logic [4:0]            STAT_SEL,
    input  logic                  STAT_CLR,
    output logic [15:0]           STAT_DATA
);
    logic [NCH-1:0] w_off_nxt, w_off;
    logic [NCH-1:0] r_gated;
    logic           r_idle;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        clk_gate_chan #(.HOLD_W(HOLD_W), .RST_ON(RST_ON)) u_ch (
            .CLK       (CLK),
            .RSTN      (RSTN),
            .i_req     (E[gi] | SE),
            .i_se      (SE),
            .i_hold    (HOLD_CYC[gi*HOLD_W +: HOLD_W]),
            .o_gclk    (GCLK[gi]),
            .o_off_nxt (w_off_nxt[gi]),
            .o_off     (w_off[gi])
        );
    end

    // Registered from next-state so GATED changes on the same edge as the channel state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_gated <= {NCH{~RST_ON}};
            r_idle  <= ~RST_ON;
        end else begin
            r_gated <= w_off_nxt;
            r_idle  <= &w_off_nxt;
        end
    end

    assign GATED    = r_gated;
    assign IDLE_ALL = r_idle;

`ifdef CLK_GATE_STATS_EN
    logic [15:0] r_stat [NCH];
    logic [15:0] w_stat_ext [32];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < NCH; i++) r_stat[i] <= '0;
        end else if (STAT_CLR) begin
            for (int i = 0; i < NCH; i++) r_stat[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++)
                if (w_off[i] && r_stat[i] != 16'hFFFF) r_stat[i] <= r_stat[i] + 16'd1;
        end
    end

    // Padding to the full 5-bit select range makes out-of-range selects read zero.
    for (genvar gi = 0; gi < 32; gi++) begin : g_ext
        if (gi < NCH) begin : g_used
            assign w_stat_ext[gi] = r_stat[gi];
        end else begin : g_pad
            assign w_stat_ext[gi] = 16'h0;
        end
    end

    assign STAT_DATA = w_stat_ext[STAT_SEL];
`else
    logic w_unused;
    assign w_unused  = ^{STAT_SEL, STAT_CLR, w_off};
    assign STAT_DATA = 16'h0;
`endif
endmodule
